// File: rtl/prog_loader_pkg.sv
// Shared types and bus field positions for the programmer byte loader.
// Build option PROG_CHECKSUM_EN adds a session checksum output.
package prog_loader_pkg;
  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    WRITE,
    FLUSH,
    DONE
  } state_t;

  localparam int PD_BYTE_MSB = 7;
  localparam int PD_STB = 8;
  localparam int PD_EN = 9;
  localparam int BYTES_PER_WORD = 4;
endpackage

// File: rtl/prog_bus_sync.sv
// Synchronizes the raw programmer bus into CLK and detects edges
// on the strobe and enable bits.
module prog_bus_sync
  import prog_loader_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [9:0] PROG_DATA,
  output logic [7:0] sync_byte,
  output logic       stb_rise,
  output logic       en_rise,
  output logic       en_fall
);
  logic [SYNC_STAGES-1:0][9:0] stage;
  logic [9:0] last;
  logic stb_q;
  logic en_q;

  assign last = stage[SYNC_STAGES-1];

  always_ff @(posedge CLK) begin
    if (RST) begin
      stage <= '0;
      stb_q <= 1'b0;
      en_q  <= 1'b0;
    end else begin
      stage <= {stage[SYNC_STAGES-2:0], PROG_DATA};
      stb_q <= last[PD_STB];
      en_q  <= last[PD_EN];
    end
  end

  assign sync_byte = last[PD_BYTE_MSB:0];
  assign stb_rise  = last[PD_STB] & ~stb_q;
  assign en_rise   = last[PD_EN] & ~en_q;
  assign en_fall   = ~last[PD_EN] & en_q;
endmodule

// File: rtl/prog_byte_loader.sv
// Packs programmer bytes into 32-bit instruction-memory writes.
// Define PROG_CHECKSUM_EN to add the CHECKSUM output.
module prog_byte_loader
  import prog_loader_pkg::*;
#(
  parameter int ADDR_WIDTH  = 14,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [9:0]            PROG_DATA,
  output logic                  MEM_WE,
  output logic [ADDR_WIDTH-1:0] MEM_ADDR,
  output logic [31:0]           MEM_DATA,
  output logic                  PROG_BUSY,
  output logic                  MCU_RST,
  output logic                  OVERFLOW,
`ifdef PROG_CHECKSUM_EN
  output logic [7:0]            CHECKSUM,
`endif
  output logic                  PARTIAL
);
  localparam logic [ADDR_WIDTH-1:0] ADDR_MAX = '1;

  state_t state, nxt;
  logic [7:0] sync_byte;
  logic stb_rise, en_rise, en_fall;
  logic [1:0] idx;
  logic [ADDR_WIDTH-1:0] addr;
  logic [31:0] word;
  logic full, ovf, part, take;

  prog_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .CLK      (CLK),
    .RST      (RST),
    .PROG_DATA(PROG_DATA),
    .sync_byte(sync_byte),
    .stb_rise (stb_rise),
    .en_rise  (en_rise),
    .en_fall  (en_fall)
  );

  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt       = state;
    take      = 1'b0;
    MEM_WE    = 1'b0;
    PROG_BUSY = 1'b0;
    MCU_RST   = 1'b0;
    unique case (state)
      IDLE: if (en_rise) nxt = LOAD;
      LOAD: begin
        PROG_BUSY = 1'b1;
        // An enable fall beats a coincident strobe
        if (en_fall) begin
          nxt = (idx != 2'd0) ? FLUSH : DONE;
        end else if (stb_rise) begin
          take = 1'b1;
          if (idx == 2'd3 && !full) nxt = WRITE;
        end
      end
      WRITE: begin
        PROG_BUSY = 1'b1;
        MEM_WE    = 1'b1;
        nxt       = en_fall ? DONE : LOAD;
      end
      FLUSH: begin
        PROG_BUSY = 1'b1;
        MEM_WE    = ~full;
        nxt       = DONE;
      end
      DONE: begin
        MCU_RST = 1'b1;
        nxt     = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      idx  <= '0;
      addr <= '0;
      word <= '0;
      full <= 1'b0;
      ovf  <= 1'b0;
      part <= 1'b0;
    end else begin
      if (state == IDLE && en_rise) begin
        idx  <= '0;
        addr <= '0;
        word <= '0;
        full <= 1'b0;
        ovf  <= 1'b0;
        part <= 1'b0;
      end
      if (take) begin
        word[{idx, 3'b000} +: 8] <= sync_byte;
        idx <= idx + 2'd1;
        if (idx == 2'd3 && full) begin
          ovf  <= 1'b1;
          word <= '0;
        end
      end
      // The last address is written once; it never wraps to zero
      if (state == WRITE) begin
        word <= '0;
        if (addr == ADDR_MAX) full <= 1'b1;
        else                  addr <= addr + 1'b1;
      end
      if (state == FLUSH) begin
        word <= '0;
        idx  <= '0;
        part <= 1'b1;
        if (full) ovf <= 1'b1;
      end
    end
  end

`ifdef PROG_CHECKSUM_EN
  always_ff @(posedge CLK) begin
    if (RST)                          CHECKSUM <= '0;
    else if (state == IDLE && en_rise) CHECKSUM <= '0;
    else if (take)                    CHECKSUM <= CHECKSUM + sync_byte;
  end
`endif

  assign MEM_ADDR = addr;
  assign MEM_DATA = word;
  assign OVERFLOW = ovf;
  assign PARTIAL  = part;
endmodule

// File: tb/tb_prog_byte_loader.sv
// Directed self-checking bench for prog_byte_loader.
// Covers default and 2-bit address instances; checksum under PROG_CHECKSUM_EN.
module tb_prog_byte_loader;
  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic [9:0] pd = '0;

  logic we, busy, mrst, ovf, part;
  logic [13:0] addr;
  logic [31:0] data;
  logic we2, busy2, mrst2, ovf2, part2;
  logic [1:0] addr2;
  logic [31:0] data2;
`ifdef PROG_CHECKSUM_EN
  logic [7:0] csum, csum2;
  logic [7:0] done_csum;
`endif

  int checks = 0;
  int failures = 0;

  logic [13:0] wa[$];
  logic [31:0] wd[$];
  logic [1:0] wa2[$];
  logic [31:0] wd2[$];
  int run = 0, maxrun = 0, pulses = 0;

  always #5 CLK = ~CLK;

  prog_byte_loader dut (
    .CLK(CLK), .RST(RST), .PROG_DATA(pd),
    .MEM_WE(we), .MEM_ADDR(addr), .MEM_DATA(data),
    .PROG_BUSY(busy), .MCU_RST(mrst), .OVERFLOW(ovf),
`ifdef PROG_CHECKSUM_EN
    .CHECKSUM(csum),
`endif
    .PARTIAL(part)
  );

  prog_byte_loader #(.ADDR_WIDTH(2)) dut2 (
    .CLK(CLK), .RST(RST), .PROG_DATA(pd),
    .MEM_WE(we2), .MEM_ADDR(addr2), .MEM_DATA(data2),
    .PROG_BUSY(busy2), .MCU_RST(mrst2), .OVERFLOW(ovf2),
`ifdef PROG_CHECKSUM_EN
    .CHECKSUM(csum2),
`endif
    .PARTIAL(part2)
  );

  always @(negedge CLK) begin
    if (we) begin
      wa.push_back(addr);
      wd.push_back(data);
      run = run + 1;
      if (run > maxrun) maxrun = run;
    end else begin
      run = 0;
    end
    if (we2) begin
      wa2.push_back(addr2);
      wd2.push_back(data2);
    end
    if (mrst) pulses = pulses + 1;
`ifdef PROG_CHECKSUM_EN
    if (mrst) done_csum = csum;
`endif
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic clear_log();
    wa.delete(); wd.delete(); wa2.delete(); wd2.delete();
    maxrun = 0; pulses = 0;
  endtask

  task automatic open_session();
    pd[9] = 1'b1;
    wait_cyc(6);
  endtask

  task automatic close_session();
    pd[9] = 1'b0;
    wait_cyc(12);
  endtask

  task automatic send_byte(input logic [7:0] b);
    pd[7:0] = b;
    wait_cyc(3);
    pd[8] = 1'b1;
    wait_cyc(6);
    pd[8] = 1'b0;
    wait_cyc(3);
  endtask

  task automatic test_reset();
    RST = 1'b1; pd = '0;
    wait_cyc(4);
    checks++;
    if ({we, addr, data, busy, mrst, ovf, part} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got we=%b a=%h d=%h b=%b r=%b o=%b p=%b exp all 0",
               we, addr, data, busy, mrst, ovf, part);
    end
    RST = 1'b0;
    wait_cyc(3);
  endtask

  task automatic test_single_word();
    clear_log();
    open_session();
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL busy_open got %b exp 1", busy); end
    send_byte(8'h13); send_byte(8'h05); send_byte(8'h10); send_byte(8'h00);
    close_session();
    checks++;
    if (wd.size() !== 1) begin failures++; $display("FAIL single_count got %0d exp 1", wd.size()); end
    checks++;
    if (wd.size() < 1 || wa[0] !== 14'd0 || wd[0] !== 32'h00100513) begin
      failures++; $display("FAIL single_word got %0d entries exp 0:00100513", wd.size());
    end
    checks++;
    if (part !== 1'b0) begin failures++; $display("FAIL single_partial got %b exp 0", part); end
    checks++;
    if (pulses !== 1) begin failures++; $display("FAIL single_mcu_rst got %0d exp 1", pulses); end
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL single_busy_after got %b exp 0", busy); end
  endtask

  task automatic test_two_words();
    clear_log();
    open_session();
    for (int i = 1; i <= 8; i++) send_byte(8'(i));
    close_session();
    checks++;
    if (wd.size() !== 2 || wa[0] !== 14'd0 || wd[0] !== 32'h04030201 ||
        wa[1] !== 14'd1 || wd[1] !== 32'h08070605) begin
      failures++; $display("FAIL two_words got %0d entries exp 0:04030201 1:08070605", wd.size());
    end
    checks++;
    if (maxrun !== 1) begin failures++; $display("FAIL we_width got %0d exp 1", maxrun); end
  endtask

  task automatic test_partial();
    clear_log();
    open_session();
    send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC);
    send_byte(8'hDD); send_byte(8'h11); send_byte(8'h22);
    close_session();
    checks++;
    if (wd.size() !== 2 || wd[0] !== 32'hDDCCBBAA || wa[1] !== 14'd1 || wd[1] !== 32'h00002211) begin
      failures++; $display("FAIL partial_flush got %0d entries exp 0:DDCCBBAA 1:00002211", wd.size());
    end
    checks++;
    if (part !== 1'b1) begin failures++; $display("FAIL partial_flag got %b exp 1", part); end
    checks++;
    if (pulses !== 1) begin failures++; $display("FAIL partial_mcu_rst got %0d exp 1", pulses); end
  endtask

  task automatic test_overflow();
    clear_log();
    open_session();
    checks++;
    if (part !== 1'b0) begin failures++; $display("FAIL sticky_clear got %b exp 0", part); end
    for (int i = 0; i < 20; i++) send_byte(8'(i + 1));
    close_session();
    checks++;
    if (wd2.size() !== 4 || wa2[0] !== 2'd0 || wa2[3] !== 2'd3 || wd2[3] !== 32'h100F0E0D) begin
      failures++; $display("FAIL ovf_writes got %0d entries exp 4 ending 3:100F0E0D", wd2.size());
    end
    checks++;
    if (ovf2 !== 1'b1) begin failures++; $display("FAIL ovf_flag got %b exp 1", ovf2); end
    checks++;
    if (wd.size() !== 5 || wa[4] !== 14'd4 || wd[4] !== 32'h14131211 || ovf !== 1'b0) begin
      failures++; $display("FAIL wide_no_ovf got %0d entries ovf=%b exp 5 ovf=0", wd.size(), ovf);
    end
  endtask

  task automatic test_rst_mid();
    clear_log();
    open_session();
    send_byte(8'h13); send_byte(8'h05);
    RST = 1'b1; pd = '0;
    wait_cyc(3);
    checks++;
    if ({we, addr, data, busy, mrst, ovf, part} !== '0) begin
      failures++; $display("FAIL rst_mid_outputs got b=%b d=%h p=%b exp all 0", busy, data, part);
    end
    RST = 1'b0;
    wait_cyc(6);
    checks++;
    if (wd.size() !== 0 || pulses !== 0) begin
      failures++; $display("FAIL rst_mid_quiet got we=%0d rst=%0d exp 0 0", wd.size(), pulses);
    end
    open_session();
    send_byte(8'h13); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    close_session();
    checks++;
    if (wd.size() !== 1 || wa[0] !== 14'd0 || wd[0] !== 32'h00000013) begin
      failures++; $display("FAIL rst_mid_new got %0d entries exp 0:00000013", wd.size());
    end
  endtask

  task automatic test_coincident();
    clear_log();
    open_session();
    send_byte(8'h01);
    pd[7:0] = 8'h05;
    wait_cyc(3);
    pd[9:8] = 2'b01;
    wait_cyc(6);
    pd[8] = 1'b0;
    wait_cyc(10);
    checks++;
    if (wd.size() !== 1 || wd[0] !== 32'h00000001) begin
      failures++; $display("FAIL coincident_drop got %0d entries exp 0:00000001", wd.size());
    end
    checks++;
    if (part !== 1'b1 || pulses !== 1) begin
      failures++; $display("FAIL coincident_close got p=%b r=%0d exp 1 1", part, pulses);
    end
`ifdef PROG_CHECKSUM_EN
    checks++;
    if (done_csum !== 8'h01) begin
      failures++; $display("FAIL coincident_csum got %h exp 01", done_csum);
    end
`endif
  endtask

`ifdef PROG_CHECKSUM_EN
  task automatic test_checksum();
    clear_log();
    open_session();
    send_byte(8'hFF); send_byte(8'h02); send_byte(8'h00); send_byte(8'h00);
    close_session();
    checks++;
    if (done_csum !== 8'h01) begin failures++; $display("FAIL checksum_done got %h exp 01", done_csum); end
    checks++;
    if (csum !== 8'h01) begin failures++; $display("FAIL checksum_hold got %h exp 01", csum); end
  endtask
`endif

  initial begin
    test_reset();
    test_single_word();
    test_two_words();
    test_partial();
    test_overflow();
    test_rst_mid();
    test_coincident();
`ifdef PROG_CHECKSUM_EN
    test_checksum();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
